// File: rtl/rf_muldiv_div_unit_if.sv
// Operand/result handshake bundle between register-file read, divide unit and write-back.
interface rf_muldiv_div_unit_if #(
   parameter int dataWidth    = 32,
   parameter int AddressWidth = 5
) ();
   logic                    in_valid;
   logic                    in_ready;
   logic [1:0]              op;
   logic [dataWidth-1:0]    dataA;
   logic [dataWidth-1:0]    dataB;
   logic [AddressWidth-1:0] RegWIn;
   logic                    out_valid;
   logic                    out_ready;
   logic [dataWidth-1:0]    dataW;
   logic [AddressWidth-1:0] RegW;

   modport master (
      output in_valid, op, dataA, dataB, RegWIn, out_ready,
      input  in_ready, out_valid, dataW, RegW
   );

   modport slave (
      input  in_valid, op, dataA, dataB, RegWIn, out_ready,
      output in_ready, out_valid, dataW, RegW
   );
endinterface

// File: rtl/rf_muldiv_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring radix-2 divider, one quotient bit per cycle,
// with a single-cycle path for divide-by-zero and signed overflow.
module rf_muldiv_div_unit #(
   parameter int dataWidth    = 32,
   parameter int AddressWidth = 5
) (
   input  logic                 Clk,
   input  logic                 reset_n,
   input  logic                 flush,
   rf_muldiv_div_unit_if.slave  bus
);
   // state  | meaning
   // S_IDLE | waiting for operands, in_ready high unless flushing
   // S_CALC | iterating, one quotient bit per edge
   // S_DONE | result presented until out_ready or flush
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

   localparam int CW = $clog2(dataWidth + 1);

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [dataWidth-1:0]    dvd_q, dvd_d;
   logic [dataWidth-1:0]    dvs_q, dvs_d;
   logic [dataWidth-1:0]    rem_q, rem_d;
   logic [dataWidth-1:0]    res_q, res_d;
   logic [AddressWidth-1:0] regw_q, regw_d;
   logic                    is_rem_q, is_rem_d;
   logic                    q_neg_q, q_neg_d;
   logic                    r_neg_q, r_neg_d;

   logic                    in_ready_c, out_valid_c;
   logic                    accept;
   logic                    signed_op, a_neg, b_neg;
   logic [dataWidth-1:0]    a_mag, b_mag;
   logic                    div_zero, sgn_ovf, special;
   logic [dataWidth-1:0]    special_res;
   logic [dataWidth:0]      rem_sh, trial;
   logic                    ge;
   logic [dataWidth-1:0]    rem_nx, quo_nx, fix_q, fix_r;

   assign accept    = bus.in_valid && in_ready_c;
   assign signed_op = ~bus.op[0];
   assign a_neg     = signed_op & bus.dataA[dataWidth-1];
   assign b_neg     = signed_op & bus.dataB[dataWidth-1];
   assign a_mag     = a_neg ? ('0 - bus.dataA) : bus.dataA;
   assign b_mag     = b_neg ? ('0 - bus.dataB) : bus.dataB;

   assign div_zero  = (bus.dataB == '0);
   assign sgn_ovf   = signed_op && (bus.dataA == {1'b1, {(dataWidth-1){1'b0}}})
                      && (bus.dataB == '1);
   assign special   = div_zero | sgn_ovf;
   assign special_res = div_zero ? (bus.op[1] ? bus.dataA : '1)
                                 : (bus.op[1] ? '0 : bus.dataA);

   // 33-bit trial subtract: the top bit is the borrow
   assign rem_sh = {rem_q, dvd_q[dataWidth-1]};
   assign trial  = rem_sh - {1'b0, dvs_q};
   assign ge     = ~trial[dataWidth];
   assign rem_nx = ge ? trial[dataWidth-1:0] : rem_sh[dataWidth-1:0];
   assign quo_nx = {dvd_q[dataWidth-2:0], ge};
   assign fix_q  = q_neg_q ? ('0 - quo_nx) : quo_nx;
   assign fix_r  = r_neg_q ? ('0 - rem_nx) : rem_nx;

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
         S_CALC: begin
            if (flush)                    state_d = S_IDLE;
            else if (cnt_q == CW'(1))     state_d = S_DONE;
         end
         S_DONE: if (flush || bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      unique case (state_q)
         S_IDLE:  in_ready_c  = reset_n && !flush;
         S_DONE:  out_valid_c = 1'b1;
         default: ;
      endcase
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.dataW     = res_q;
   assign bus.RegW      = regw_q;

   always_comb begin
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      res_d    = res_q;
      regw_d   = regw_q;
      is_rem_d = is_rem_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      if (state_q == S_IDLE && accept) begin
         cnt_d    = CW'(dataWidth);
         dvd_d    = a_mag;
         dvs_d    = b_mag;
         rem_d    = '0;
         regw_d   = bus.RegWIn;
         is_rem_d = bus.op[1];
         q_neg_d  = a_neg ^ b_neg;
         r_neg_d  = a_neg;
         if (special) res_d = special_res;
      end else if (state_q == S_CALC && !flush) begin
         cnt_d = cnt_q - CW'(1);
         dvd_d = quo_nx;
         rem_d = rem_nx;
         if (cnt_q == CW'(1)) res_d = is_rem_q ? fix_r : fix_q;
      end
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         res_q    <= '0;
         regw_q   <= '0;
         is_rem_q <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         res_q    <= res_d;
         regw_q   <= regw_d;
         is_rem_q <= is_rem_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
      end
   end
endmodule

// File: tb/tb_rf_muldiv_div_unit.sv
// Bench for rf_muldiv_div_unit: directed vector table, handshake corner sequences,
// and random operations against an arithmetic reference.
module tb_rf_muldiv_div_unit;
   logic Clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush = 1'b0;

   rf_muldiv_div_unit_if #(.dataWidth(32), .AddressWidth(5)) bus ();

   rf_muldiv_div_unit #(.dataWidth(32), .AddressWidth(5)) dut (
      .Clk     (Clk),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'd0:    return sa / sb;
         2'd1:    return a / b;
         2'd2:    return sa % sb;
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output bit ok);
      bus.op       = op;
      bus.dataA    = a;
      bus.dataB    = b;
      bus.RegWIn   = rd;
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      if (ok) begin
         @(posedge Clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.op       = 2'($urandom);
      bus.dataA    = $urandom;
      bus.dataB    = $urandom;
      bus.RegWIn   = 5'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge Clk);
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd,
                            input logic [31:0] exp, input int explat);
      bit ok;
      int lat;
      issue(op, a, b, rd, ok);
      chk({tag, "/accept"}, 32'(ok), 32'd1);
      if (ok) begin
         wait_valid(lat);
         chk({tag, "/latency"}, lat, explat);
         chk({tag, "/dataW"}, bus.dataW, exp);
         chk({tag, "/RegW"}, 32'(bus.RegW), 32'(rd));
         consume();
         chk({tag, "/valid_drop"}, 32'(bus.out_valid), 32'd0);
      end
   endtask

   initial begin
      bit ok;
      int lat;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      logic [4:0]  rrd;
      int          sel, hold;

      vecs[0]  = '{2'd0, 32'd20,         32'hFFFF_FFFD, 5'd7,  32'hFFFF_FFFA, 33};
      vecs[1]  = '{2'd2, 32'd20,         32'hFFFF_FFFD, 5'd7,  32'd2,         33};
      vecs[2]  = '{2'd1, 32'hFFFF_FFFF,  32'd2,         5'd1,  32'h7FFF_FFFF, 33};
      vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,         5'd2,  32'hFFFF_FFFF, 33};
      vecs[4]  = '{2'd3, 32'hFFFF_FFF9,  32'd2,         5'd3,  32'd1,         33};
      vecs[5]  = '{2'd1, 32'd5,          32'd0,         5'd4,  32'hFFFF_FFFF, 1};
      vecs[6]  = '{2'd2, 32'd5,          32'd0,         5'd5,  32'd5,         1};
      vecs[7]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd6,  32'h8000_0000, 1};
      vecs[8]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'd0,         1};
      vecs[9]  = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'd0,         33};
      vecs[10] = '{2'd0, 32'd0,          32'd5,         5'd0,  32'd0,         33};
      vecs[11] = '{2'd0, 32'hFFFF_FFF9,  32'd0,         5'd10, 32'hFFFF_FFFF, 1};
      vecs[12] = '{2'd3, 32'd7,          32'd0,         5'd11, 32'd7,         1};
      vecs[13] = '{2'd0, 32'hFFFF_FFF9,  32'd2,         5'd12, 32'hFFFF_FFFD, 33};
      vecs[14] = '{2'd1, 32'd1,          32'hFFFF_FFFF, 5'd13, 32'd0,         33};
      vecs[15] = '{2'd2, 32'h8000_0000,  32'd3,         5'd31, 32'hFFFF_FFFE, 33};

      bus.in_valid  = 1'b0;
      bus.op        = 2'd0;
      bus.dataA     = '0;
      bus.dataB     = '0;
      bus.RegWIn    = '0;
      bus.out_ready = 1'b1;

      // reset values
      #3;
      chk("rst/in_ready",  32'(bus.in_ready),  32'd0);
      chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst/dataW",     bus.dataW,          32'd0);
      chk("rst/RegW",      32'(bus.RegW),      32'd0);
      repeat (3) @(negedge Clk);
      reset_n = 1'b1;
      #1;
      chk("rst/in_ready_after", 32'(bus.in_ready), 32'd1);
      @(negedge Clk);

      for (int i = 0; i < NV; i++)
         run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].exp, vecs[i].lat);

      // backpressure in DONE
      bus.out_ready = 1'b0;
      issue(2'd1, 32'd100, 32'd7, 5'd3, ok);
      chk("bp/accept", 32'(ok), 32'd1);
      wait_valid(lat);
      chk("bp/latency", lat, 33);
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         chk($sformatf("bp/hold%0d/valid", k), 32'(bus.out_valid), 32'd1);
         chk($sformatf("bp/hold%0d/dataW", k), bus.dataW, 32'd14);
         chk($sformatf("bp/hold%0d/in_ready", k), 32'(bus.in_ready), 32'd0);
      end
      consume();
      chk("bp/valid_drop", 32'(bus.out_valid), 32'd0);
      chk("bp/in_ready",   32'(bus.in_ready),  32'd1);

      // flush mid-CALC, then a new op right away
      issue(2'd0, 32'd1000, 32'd3, 5'd4, ok);
      chk("fl/accept", 32'(ok), 32'd1);
      repeat (10) @(negedge Clk);
      flush = 1'b1;
      @(posedge Clk);
      #1 flush = 1'b0;
      @(negedge Clk);
      chk("fl/in_ready",  32'(bus.in_ready),  32'd1);
      chk("fl/out_valid", 32'(bus.out_valid), 32'd0);
      run_check("fl/next", 2'd1, 32'd9, 32'd3, 5'd6, 32'd3, 33);

      // flush together with in_valid in IDLE: nothing accepted
      bus.op = 2'd1; bus.dataA = 32'd5; bus.dataB = 32'd0; bus.RegWIn = 5'd2;
      bus.in_valid = 1'b1;
      flush = 1'b1;
      #1;
      chk("fli/in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge Clk);
      #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge Clk);
      chk("fli/out_valid", 32'(bus.out_valid), 32'd0);
      chk("fli/in_ready",  32'(bus.in_ready),  32'd1);

      // flush while holding a result in DONE
      bus.out_ready = 1'b0;
      issue(2'd1, 32'd100, 32'd7, 5'd3, ok);
      wait_valid(lat);
      chk("fld/latency", lat, 33);
      flush = 1'b1;
      @(posedge Clk);
      #1 flush = 1'b0;
      @(negedge Clk);
      chk("fld/out_valid", 32'(bus.out_valid), 32'd0);
      chk("fld/in_ready",  32'(bus.in_ready),  32'd1);
      bus.out_ready = 1'b1;
      run_check("fld/next", 2'd1, 32'd9, 32'd3, 5'd17, 32'd3, 33);

      // asynchronous reset mid-CALC
      issue(2'd1, 32'd100, 32'd7, 5'd5, ok);
      repeat (5) @(negedge Clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst/out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst/dataW",     bus.dataW,          32'd0);
      chk("arst/RegW",      32'(bus.RegW),      32'd0);
      chk("arst/in_ready",  32'(bus.in_ready),  32'd0);
      @(negedge Clk);
      reset_n = 1'b1;
      #1;
      chk("arst/in_ready_after", 32'(bus.in_ready), 32'd1);
      run_check("arst/next", 2'd1, 32'd9, 32'd3, 5'd9, 32'd3, 33);

      // random operations against the reference
      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         rrd = 5'($urandom);
         sel = $urandom_range(0, 7);
         case (sel)
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: rb = 32'hFFFF_FFFF;
            4: ra = 32'($urandom_range(0, 100));
            default: ;
         endcase
         hold = $urandom_range(0, 3);
         bus.out_ready = (hold == 0);
         issue(rop, ra, rb, rrd, ok);
         chk($sformatf("rnd%0d/accept", n), 32'(ok), 32'd1);
         if (ok) begin
            wait_valid(lat);
            chk($sformatf("rnd%0d/latency", n), lat, ref_lat(rop, ra, rb));
            chk($sformatf("rnd%0d/dataW", n), bus.dataW, ref_div(rop, ra, rb));
            chk($sformatf("rnd%0d/RegW", n), 32'(bus.RegW), 32'(rrd));
            if (hold != 0) begin
               repeat (hold) @(negedge Clk);
               chk($sformatf("rnd%0d/held", n), bus.dataW, ref_div(rop, ra, rb));
            end
            consume();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
